// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the two-port shared-shifter controller:
// widths, shift-mode encodings and controller state encoding.
package shift_arbiter_pkg;

  localparam int WIDTH = 16;
  localparam int AMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    MODE_SLL  = 2'b00,
    MODE_SRA  = 2'b01,
    MODE_ROR  = 2'b10,
    MODE_PASS = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the two requesters and the shared shifter.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
interface shift_arbiter_if;
  import shift_arbiter_pkg::*;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_data0;
  logic [WIDTH-1:0] req_data1;
  logic [AMT_W-1:0] req_amt0;
  logic [AMT_W-1:0] req_amt1;
  mode_t            req_mode0;
  mode_t            req_mode1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_data0, req_data1, req_amt0, req_amt1,
           req_mode0, req_mode1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data0, req_data1, req_amt0, req_amt1,
           req_mode0, req_mode1, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/shift_arbiter_shift_core.sv
// Combinational logarithmic shifter: stages of 1/2/4/8 selected by the amount bits.
// Pass-through mode returns the operand regardless of amount.
module shift_core
  import shift_arbiter_pkg::*;
(
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  mode_t            mode,
  output logic [WIDTH-1:0] result
);

  function automatic logic [WIDTH-1:0] shift_stage(
    input logic [WIDTH-1:0] x,
    input int               s,
    input mode_t            m
  );
    logic [WIDTH-1:0] r;
    case (m)
      MODE_SLL: r = x << s;
      MODE_SRA: r = $signed(x) >>> s;
      MODE_ROR: r = (x >> s) | (x << (WIDTH - s));
      default:  r = x;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] acc;

  always_comb begin
    acc = data;
    for (int k = 0; k < AMT_W; k++) begin
      if (amt[k]) acc = shift_stage(acc, 1 << k, mode);
    end
    result = (mode == MODE_PASS) ? data : acc;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin controller sharing one shift_core between two requesters.
// One request in flight: accept in IDLE, compute in SHIFT, hold result in RESP.
module shift_arbiter
  import shift_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  shift_arbiter_if.slave        bus,
  output state_t                dbg_state
);

  state_t           state, state_next;
  logic             ptr;
  logic             owner;
  logic             grant_port;
  logic             accept;
  logic [WIDTH-1:0] op_data;
  logic [AMT_W-1:0] op_amt;
  mode_t            op_mode;
  logic [WIDTH-1:0] rsp_data_q;
  logic [WIDTH-1:0] core_result;

  shift_core u_shift_core (
    .data   (op_data),
    .amt    (op_amt),
    .mode   (op_mode),
    .result (core_result)
  );

  // With both ports valid the pointer decides; otherwise the lone requester wins.
  always_comb begin
    state_next    = state;
    grant_port    = 1'b0;
    accept        = 1'b0;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid != 2'b00) begin
          grant_port    = (bus.req_valid == 2'b11) ? ptr : bus.req_valid[1];
          accept        = 1'b1;
          bus.req_ready = {grant_port, ~grant_port};
          state_next    = ST_SHIFT;
        end
      end
      ST_SHIFT: state_next = ST_RESP;
      ST_RESP: begin
        bus.rsp_valid = {owner, ~owner};
        if (bus.rsp_ready[owner]) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= 1'b0;
      owner      <= 1'b0;
      op_data    <= '0;
      op_amt     <= '0;
      op_mode    <= MODE_PASS;
      rsp_data_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        owner   <= grant_port;
        ptr     <= ~grant_port;
        op_data <= grant_port ? bus.req_data1 : bus.req_data0;
        op_amt  <= grant_port ? bus.req_amt1  : bus.req_amt0;
        op_mode <= grant_port ? bus.req_mode1 : bus.req_mode0;
      end
      if (state == ST_SHIFT) rsp_data_q <= core_result;
    end
  end

  assign bus.rsp_data = rsp_data_q;
  assign dbg_state    = state;

endmodule
